// File: rtl/gcd_pkg.sv
// Shared types for the subtractive GCD engine: controller state and the
// datapath mux selects used by both controller and datapath.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

    typedef enum logic [1:0] {
        A_SEL_LOAD = 2'd0,
        A_SEL_B    = 2'd1,
        A_SEL_SUB  = 2'd2
    } a_sel_e;

    typedef enum logic {
        B_SEL_LOAD = 1'b0,
        B_SEL_A    = 1'b1
    } b_sel_e;

endpackage

// File: rtl/register.sv
// Generic enabled flop with asynchronous active-low reset to RST_VAL.
module register #(
    parameter int          W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         wen,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            q <= RST_VAL;
        else if (wen)
            q <= d;
    end

endmodule

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtractive GCD engine: sequences operand load,
// swap/subtract iterations and the response handshake with a timeout flag.
module gcd_ctrl
    import gcd_pkg::*;
#(
    parameter int WL       = 16,
    parameter int MAX_ITER = 2**WL-1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          req_val,
    output logic          req_rdy,
    output logic          resp_val,
    input  logic          resp_rdy,
    output logic          resp_err,
    input  logic          a_lt_b,
    input  logic          b_zero,
    input  logic [WL-1:0] cnt,
    output a_sel_e        a_sel,
    output b_sel_e        b_sel,
    output logic          a_en,
    output logic          b_en,
    output logic          cnt_en,
    output logic          cnt_rst
);

    localparam logic [WL-1:0] MAX_CNT = WL'(MAX_ITER);

    gcd_state_e state, state_nxt;
    logic       err;
    logic       timeout;
    logic       err_wen;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // b_zero wins over the budget check so a result finishing on the last
    // permitted iteration is still reported as good.
    assign timeout = (state == CALC) && !b_zero && (cnt == MAX_CNT);

    always_comb begin
        state_nxt = state;
        a_sel     = A_SEL_LOAD;
        b_sel     = B_SEL_LOAD;
        a_en      = 1'b0;
        b_en      = 1'b0;
        cnt_en    = 1'b0;
        cnt_rst   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_val) begin
                    a_en      = 1'b1;
                    b_en      = 1'b1;
                    cnt_en    = 1'b1;
                    cnt_rst   = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (b_zero || timeout) begin
                    state_nxt = DONE;
                end else if (a_lt_b) begin
                    a_sel  = A_SEL_B;
                    b_sel  = B_SEL_A;
                    a_en   = 1'b1;
                    b_en   = 1'b1;
                    cnt_en = 1'b1;
                end else begin
                    a_sel  = A_SEL_SUB;
                    a_en   = 1'b1;
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                if (resp_rdy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // err is set on the timeout exit from CALC and cleared on the response
    // handshake; it holds in between so resp_err is stable under backpressure.
    assign err_wen = timeout || ((state == DONE) && resp_rdy);

    register #(.W(1), .RST_VAL(1'b0)) u_err (
        .clk   (clk),
        .rst_b (rst_b),
        .wen   (err_wen),
        .d     (timeout),
        .q     (err)
    );

    assign req_rdy  = (state == IDLE);
    assign resp_val = (state == DONE);
    assign resp_err = (state == DONE) && err;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: two controllers (full and 4-iteration budget), each
// driving a behavioural GCD datapath; results checked against a scoreboard.
module tb_gcd_ctrl;
    import gcd_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] c;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic [1:0]        req_val = '0;
    logic [1:0]        req_rdy;
    logic [1:0]        resp_val;
    logic [1:0]        resp_rdy = '0;
    logic [1:0]        resp_err;
    logic [1:0]        a_lt_b;
    logic [1:0]        b_zero;
    logic [1:0][1:0]   a_sel;
    logic [1:0]        b_sel;
    logic [1:0]        a_en, b_en, cnt_en, cnt_rst;
    logic [1:0][15:0]  opa = '0, opb = '0;
    logic [1:0][15:0]  dp_a = '0, dp_b = '0, dp_c = '0;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [1:0] ref_ops[$];
    logic [1:0] seen_ops[$];

    always #5 clk = ~clk;

    gcd_ctrl #(.WL(16)) u_dut0 (
        .clk(clk), .rst_b(rst_b), .req_val(req_val[0]), .req_rdy(req_rdy[0]),
        .resp_val(resp_val[0]), .resp_rdy(resp_rdy[0]), .resp_err(resp_err[0]),
        .a_lt_b(a_lt_b[0]), .b_zero(b_zero[0]), .cnt(dp_c[0]),
        .a_sel(a_sel[0]), .b_sel(b_sel[0]), .a_en(a_en[0]), .b_en(b_en[0]),
        .cnt_en(cnt_en[0]), .cnt_rst(cnt_rst[0])
    );

    gcd_ctrl #(.WL(16), .MAX_ITER(4)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .req_val(req_val[1]), .req_rdy(req_rdy[1]),
        .resp_val(resp_val[1]), .resp_rdy(resp_rdy[1]), .resp_err(resp_err[1]),
        .a_lt_b(a_lt_b[1]), .b_zero(b_zero[1]), .cnt(dp_c[1]),
        .a_sel(a_sel[1]), .b_sel(b_sel[1]), .a_en(a_en[1]), .b_en(b_en[1]),
        .cnt_en(cnt_en[1]), .cnt_rst(cnt_rst[1])
    );

    // Behavioural datapath: operand registers, subtractor, comparator, counter.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (a_en[i[0]]) begin
                case (a_sel[i[0]])
                    A_SEL_LOAD: dp_a[i[0]] <= opa[i[0]];
                    A_SEL_B:    dp_a[i[0]] <= dp_b[i[0]];
                    default:    dp_a[i[0]] <= dp_a[i[0]] - dp_b[i[0]];
                endcase
            end
            if (b_en[i[0]])
                dp_b[i[0]] <= (b_sel[i[0]] == B_SEL_A) ? dp_a[i[0]] : opb[i[0]];
            if (cnt_en[i[0]])
                dp_c[i[0]] <= cnt_rst[i[0]] ? 16'd0 : dp_c[i[0]] + 16'd1;
        end
    end

    always_comb begin
        a_lt_b = '0;
        b_zero = '0;
        for (int i = 0; i < 2; i++) begin
            a_lt_b[i[0]] = dp_a[i[0]] < dp_b[i[0]];
            b_zero[i[0]] = dp_b[i[0]] == 16'd0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference algorithm: termination check, then budget, then swap/subtract.
    task automatic ref_gcd(input logic [15:0] a_i, input logic [15:0] b_i,
                           input int maxit, output exp_t e);
        logic [15:0] a, b, t;
        int c;
        a = a_i; b = b_i; c = 0;
        e.err = 1'b0;
        ref_ops.delete();
        while (1) begin
            if (b == 16'd0) break;
            if (c == maxit) begin e.err = 1'b1; break; end
            if (a < b) begin
                t = a; a = b; b = t;
                ref_ops.push_back(A_SEL_B);
            end else begin
                a = a - b;
                ref_ops.push_back(A_SEL_SUB);
            end
            c++;
        end
        e.a = a;
        e.c = 16'(c);
    endtask

    task automatic run(input bit g, input logic [15:0] a, input logic [15:0] b,
                       input int hold, input bit pulse);
        exp_t e, got;
        int   k;
        bit   stable;
        ref_gcd(a, b, g ? 4 : 65535, e);
        sb.push_back(e);
        seen_ops.delete();
        @(negedge clk);
        check("req_rdy_idle", 32'(req_rdy[g]), 32'd1);
        opa[g] = a; opb[g] = b; req_val[g] = 1'b1;
        #1;
        check("load_strobes", 32'({a_en[g], b_en[g], cnt_en[g], cnt_rst[g]}), 32'hf);
        @(posedge clk);
        #1 req_val[g] = 1'b0;
        k = 0;
        while (k < 300) begin
            @(negedge clk);
            if (resp_val[g]) break;
            if (cnt_en[g] && !cnt_rst[g]) seen_ops.push_back(a_sel[g]);
            if (pulse) begin
                req_val[g] = 1'b1;
                #1;
                check("calc_ignore_req", 32'(cnt_rst[g]), 32'd0);
                req_val[g] = 1'b0;
            end
            @(posedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(e.c) + 32'd1);
        check("ops_len", 32'(seen_ops.size()), 32'(ref_ops.size()));
        if (seen_ops.size() == ref_ops.size())
            foreach (ref_ops[i]) check("op", 32'(seen_ops[i]), 32'(ref_ops[i]));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            if (pulse) req_val[g] = 1'b1;
            #1;
            stable = resp_val[g] && (resp_err[g] == e.err) &&
                     !a_en[g] && !b_en[g] && !cnt_en[g];
            check("backpressure_stable", 32'(stable), 32'd1);
            req_val[g] = 1'b0;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check("result_a", 32'(dp_a[g]), 32'(got.a));
            check("result_cnt", 32'(dp_c[g]), 32'(got.c));
            check("resp_err", 32'(resp_err[g]), 32'(got.err));
        end
        resp_rdy[g] = 1'b1;
        @(posedge clk);
        #1 resp_rdy[g] = 1'b0;
        check("post_resp_idle", 32'({req_rdy[g], resp_val[g], resp_err[g]}), 32'b100);
    endtask

    initial begin
        #2;
        check("rst_moore", 32'({req_rdy, resp_val, resp_err}), 32'b110000);
        check("rst_enables", 32'({a_en, b_en, cnt_en, cnt_rst}), 32'd0);
        check("rst_sel", 32'({a_sel, b_sel}), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;

        run(1'b0, 16'd15, 16'd6, 0, 1'b0);
        run(1'b0, 16'd0,  16'd0, 0, 1'b0);
        run(1'b0, 16'd0,  16'd5, 0, 1'b0);
        run(1'b0, 16'd7,  16'd7, 0, 1'b0);
        run(1'b1, 16'd15, 16'd6, 0, 1'b0);
        run(1'b1, 16'd8,  16'd4, 0, 1'b0);
        run(1'b1, 16'd1000, 16'd1, 2, 1'b1);
        run(1'b0, 16'd48, 16'd18, 5, 1'b1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        opa[0] = 16'd15; opb[0] = 16'd6; req_val[0] = 1'b1;
        @(posedge clk);
        #1 req_val[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_calc_busy", 32'(req_rdy[0]), 32'd0);
        rst_b = 1'b0;
        #1;
        check("async_rst_rdy", 32'(req_rdy[0]), 32'd1);
        check("async_rst_en", 32'({a_en[0], b_en[0], cnt_en[0], cnt_rst[0]}), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;

        run(1'b0, 16'd12, 16'd18, 0, 1'b0);
        run(1'b0, 16'd270, 16'd192, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_ctrl.md
# gcd_ctrl

Control unit for the subtractive GCD engine. Accepts operand requests over a valid/ready handshake and sequences the A/B operand registers and the shared iteration counter until B reaches zero. Returns a result-valid handshake with an error flag if a configurable iteration budget is exhausted. Sits between the request/response interface and the GCD datapath (operand registers, subtractor, comparator, iteration counter); it holds no operand data itself.

## Interface
- WL, 16: datapath and iteration-counter width
- MAX_ITER, 2**WL-1: iteration budget; must satisfy 1 ≤ MAX_ITER ≤ 2**WL-1
- clk  in  1  clock, rising-edge
- rst_b  in  1  asynchronous, active-low reset
- req_val  in  1  operands valid on datapath inputs
- req_rdy  out  1  controller idle, can accept
- resp_val  out  1  result in A register is valid
- resp_rdy  in  1  consumer accepts result
- resp_err  out  1  iteration budget exhausted; result invalid
- a_lt_b  in  1  datapath status: A < B, unsigned
- b_zero  in  1  datapath status: B == 0
- cnt  in  WL  iteration counter value
- a_sel  out  2  A mux select: LOAD / B / SUB (A−B)
- b_sel  out  1  B mux select: LOAD / A
- a_en  out  1  A register write enable
- b_en  out  1  B register write enable
- cnt_en  out  1  counter write enable
- cnt_rst  out  1  counter synchronous clear, qualified by cnt_en

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - req_rdy=1.
  - On req_val: a_sel=LOAD, b_sel=LOAD, a_en=b_en=1, cnt_en=cnt_rst=1 → CALC.
- CALC, evaluated in priority order:
  1. b_zero → DONE, err=0.
  2. cnt == MAX_ITER → DONE, err=1; no register writes.
  3. a_lt_b → swap: a_sel=B, b_sel=A, a_en=b_en=1, cnt_en=1.
  4. Otherwise subtract: a_sel=SUB, a_en=1, b_en=0, cnt_en=1.
- DONE:
  - resp_val=1, resp_err=err.
  - On resp_rdy → IDLE, err cleared.
  - All enables 0, so A and cnt hold the result and the operation count.
- Enables not listed for a state are 0. Select values are don't-care when the matching enable is 0; drive LOAD.
- req_val is ignored outside IDLE. No request queuing.
- err is a registered flag, set only on the CALC→DONE timeout transition.
- Counter wrap is impossible: the timeout check precedes every increment, and MAX_ITER ≤ 2**WL−1.

## Timing
- Reset values:
  - State=IDLE, err=0.
  - req_rdy=1, resp_val=0, resp_err=0.
  - All enables=0, a_sel=LOAD, b_sel=LOAD.
- Output dependencies:
  - req_rdy, resp_val, resp_err: Moore, functions of registered state only.
  - Datapath controls: Mealy, combinational from state plus req_val/a_lt_b/b_zero/cnt.
- Request accepted at edge t0 (req_val & req_rdy). N datapath iterations occupy CALC from t0 to t0+N. The terminating check happens in the cycle after t0+N. resp_val is high after edge t0+N+1.
- Response handshake at edge t1 → req_rdy high after t1. Back-to-back requests are therefore separated by at least one IDLE cycle.
- resp_val/resp_err remain stable while resp_rdy=0.
- rst_b assertion at any time forces IDLE and clears err immediately. Datapath register contents are not the controller's concern.

## Structure
- gcd_pkg holds:
  - state enum (IDLE, CALC, DONE)
  - a_sel enum (A_SEL_LOAD, A_SEL_B, A_SEL_SUB)
  - b_sel enum (B_SEL_LOAD, B_SEL_A)
- The same enums are imported by the datapath.
- The err flag and state are flops with asynchronous active-low reset. The existing `register` module is reused for err (wen = set-or-clear condition).
- Single module; no further sub-module. Next-state and output logic share one always_comb.

## Test plan
- Operands (15,6), resp_rdy=1:
  - Expected sequence: SUB, SUB, swap, SUB, SUB, swap.
  - resp_val rises after t0+7.
  - A=3, cnt=6, resp_err=0.
- Operands (0,0): DONE after t0+1, cnt=0, resp_err=0. Operands (0,5): one swap, A=5, cnt=1.
- MAX_ITER=4, operands (15,6): four operations, then DONE after t0+5 with resp_err=1, cnt=4. Next request (8,4) completes with resp_err=0.
- Backpressure: hold resp_rdy=0 for 5 cycles in DONE.
  - resp_val, resp_err, a_en, b_en and cnt_en must stay stable.
  - req_val pulses during CALC/DONE must be ignored: no load strobes.
- Drop rst_b mid-CALC for (15,6):
  - req_rdy=1 and all enables 0 immediately, before the next edge.
  - After release, (12,18) completes with A=6, resp_err=0.
